score_display_scanner: RTL and testbench

Multiplexed 5-digit seven-segment driver that consumes the 20-bit packed BCD score from the score pipeline and scans it onto a common-anode display. The score is latched once per scan frame, so a frame never mixes digits from two scores. Each digit slot has a programmable ghost-suppression dead time, and invalid BCD nibbles are shown visibly. It sits between the scorer's `bcd_score` output and the board's segment/anode pins.

---
 rtl/score_display_scanner.sv | 121 ++++++++++++
 tb/tb_score_display_scanner.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_scanner.sv
// Multiplexed 5-digit common-anode seven-segment scanner with per-frame score snapshot and per-slot dead time.
// Optional leading-zero blanking is enabled by defining SCORE_LEADING_ZERO_BLANK_EN.
module score_display_scanner #(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] bcd_score,
    output logic [6:0]  seg_n,
    output logic [4:0]  an_n,
    output logic        frame_start
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    // Slot phase is a pure function of cnt; scan_state is kept as a named signal for probing.
    typedef enum logic {
        DARK = 1'b0,
        LIT  = 1'b1
    } scan_e;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [19:0]   snap;
    logic          tick;
    logic          frame_edge;
    scan_e         scan_state;
    logic [4:0]    blank;
    logic [3:0]    digit;
    logic          digit_blank;
    logic [6:0]    seg_next;
    logic [4:0]    an_next;

    assign tick       = (cnt == CNT_MAX);
    assign frame_edge = tick && (idx == 3'd4);
    assign scan_state = (int'(cnt) < DEAD_CYCLES) ? DARK : LIT;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            idx  <= 3'd0;
            snap <= 20'd0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            end
            if (frame_edge) begin
                snap <= bcd_score;
            end
        end
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; a digit stays blank until a non-zero nibble is seen at or above it.
    always_comb begin
        logic nz;
        nz    = 1'b0;
        blank = 5'd0;
        for (int i = 4; i >= 1; i--) begin
            nz       = nz | (snap[4*i +: 4] != 4'd0);
            blank[i] = !nz;
        end
    end
`else
    assign blank = 5'd0;
`endif

    always_comb begin
        digit       = 4'd0;
        digit_blank = 1'b1;
        case (idx)
            3'd0: begin digit = snap[3:0];   digit_blank = blank[0]; end
            3'd1: begin digit = snap[7:4];   digit_blank = blank[1]; end
            3'd2: begin digit = snap[11:8];  digit_blank = blank[2]; end
            3'd3: begin digit = snap[15:12]; digit_blank = blank[3]; end
            3'd4: begin digit = snap[19:16]; digit_blank = blank[4]; end
            default: begin digit = 4'd0;     digit_blank = 1'b1;     end
        endcase
    end

    always_comb begin
        an_next  = 5'h1F;
        seg_next = 7'h7F;
        if (scan_state == LIT && !digit_blank) begin
            an_next  = ~(5'b00001 << idx);
            seg_next = decode(digit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_n       <= 7'h7F;
            an_n        <= 5'h1F;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= seg_next;
            an_n        <= an_next;
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_score_display_scanner.sv
// Self-checking bench for score_display_scanner: a cycle model feeds an expected queue that is compared each clock.
// Expectations follow SCORE_LEADING_ZERO_BLANK_EN when that macro is defined for the build.
module tb_score_display_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEAD    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] bcd_score = 20'h12345;
    logic [6:0]  seg_n;
    logic [4:0]  an_n;
    logic        frame_start;

    always #5 clk = ~clk;

    score_display_scanner #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk),
        .rst(rst),
        .bcd_score(bcd_score),
        .seg_n(seg_n),
        .an_n(an_n),
        .frame_start(frame_start)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [12:0] exp_q[$];
    int          m_cnt;
    int          m_idx;
    logic [19:0] m_snap;
    int          steps_since_rel;
    int          first_fs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {frame_start, an_n, seg_n} one clock after the model's current state.
    function automatic logic [12:0] model_out();
        int top;
        logic [4:0] an;
        logic [6:0] seg;
        logic fs;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        top = 0;
        for (int i = 0; i < 5; i++) if (m_snap[4*i +: 4] != 4'd0) top = i;
`else
        top = 4;
`endif
        an  = 5'h1F;
        seg = 7'h7F;
        if (m_cnt >= DEAD && m_idx <= top) begin
            an  = 5'h1F & ~(5'b00001 << m_idx);
            seg = seg_of(m_snap[4*m_idx +: 4]);
        end
        fs = (m_cnt == CLK_DIV - 1) && (m_idx == 4);
        return {fs, an, seg};
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_snap = 20'd0;
    endtask

    task automatic step();
        logic [12:0] e;
        exp_q.push_back(model_out());
        if (m_cnt == CLK_DIV - 1) begin
            m_cnt = 0;
            if (m_idx == 4) begin
                m_idx  = 0;
                m_snap = bcd_score;
            end else begin
                m_idx++;
            end
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
        steps_since_rel++;
        e = exp_q.pop_front();
        check_val("scan", {19'd0, frame_start, an_n, seg_n}, {19'd0, e});
        if (frame_start && first_fs < 0) first_fs = steps_since_rel;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int idx, input int cnt);
        int k;
        k = 0;
        while (!(m_idx == idx && m_cnt == cnt) && k < 100) begin
            step();
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            $display("FAIL run_to: idx %0d cnt %0d not reached in %0d clocks", idx, cnt, k);
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_dark", {frame_start, an_n, seg_n}, {1'b0, 5'h1F, 7'h7F});
        end
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        steps_since_rel = 0;
        first_fs        = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lz_hi;
        model_reset();
        steps_since_rel = 0;
        first_fs        = -1;

        // Held in reset with a live score on the input.
        hold_reset(4);

        // First frame after release shows 0; snapshot of 12345 lands at clock 20.
        release_rst();
        run(2);
        check_val("first_d0_an", an_n, 5'h1E);
        check_val("first_d0_seg", seg_n, 7'h40);
        run(18);
        check_val("first_fs", first_fs, 20);
        run(2);
        check_val("slot0_an", an_n, 5'h1E);
        check_val("slot0_seg", seg_n, 7'h12);
        run(17);
        check_val("slot4_an", an_n, 5'h0F);
        check_val("slot4_seg", seg_n, 7'h79);
        run(1);

        // Leading zeros: digits 2..4 dark only with blanking built in.
        bcd_score = 20'h00070;
        run(25);
        lz_hi = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            lz_hi = lz_hi & (&an_n[4:2]);
        end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        check_val("lz_an_high", lz_hi, 1);
`else
        check_val("lz_an_high", lz_hi, 0);
`endif

        // Score changes mid-frame; the new value waits for the next snapshot.
        bcd_score = 20'h00011;
        run(25);
        run_to(2, 1);
        bcd_score = 20'h00099;
        run_to(0, 0);
        run(2);
        check_val("mid_new_an", an_n, 5'h1E);
        check_val("mid_new_seg", seg_n, 7'h10);

        // Invalid nibble shows a dash.
        bcd_score = 20'h0000A;
        run(25);
        run_to(0, 1);
        run(1);
        check_val("inv_an", an_n, 5'h1E);
        check_val("inv_seg", seg_n, 7'h3F);

        // Random valid scores.
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 5; d++) bcd_score[4*d +: 4] = 4'($urandom_range(0, 9));
            run(45);
        end

        // Asynchronous reset during slot 3.
        bcd_score = 20'h12345;
        run_to(3, 2);
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_async", {frame_start, an_n, seg_n}, {1'b0, 5'h1F, 7'h7F});
        hold_reset(3);
        release_rst();
        run(2);
        check_val("rerel_d0_an", an_n, 5'h1E);
        check_val("rerel_d0_seg", seg_n, 7'h40);
        run(18);
        check_val("rerel_fs", first_fs, 20);
        run(5);

        check_val("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
